mips_multicycle: RTL

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_multicycle.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle
// Brief    : Multicycle MIPS subset core sharing one instruction/data memory
//            port, with sticky illegal-instruction halt and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      pc,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,  S_ADDIWB = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_retire;
    logic [31:0]       r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_alu;
    logic [31:0]       r_mdr;
    logic [31:0]       r_target;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_retired;
    logic [31:0]       r_rf [0:31];

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [31:0]       w_simm;
    logic [31:0]       w_alu;
    logic              w_funct_ok;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};

    assign w_funct_ok = (w_funct == c_FN_ADD) || (w_funct == c_FN_SUB) ||
                        (w_funct == c_FN_AND) || (w_funct == c_FN_OR)  ||
                        (w_funct == c_FN_SLT);

    assign pc      = r_pc;
    assign illegal = r_illegal;
    assign retired = r_retired;

    always_comb begin
        w_alu = '0;
        case (w_funct)
            c_FN_ADD: w_alu = r_a + r_b;
            c_FN_SUB: w_alu = r_a - r_b;
            c_FN_AND: w_alu = r_a & r_b;
            c_FN_OR:  w_alu = r_a | r_b;
            c_FN_SLT: w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = w_funct_ok ? S_EXEC : S_HALT;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_HALT;
                endcase
            end
            S_MEMADR: w_next = (w_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Bus outputs are gated by reset so an in-flight request drops the instant reset asserts.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = r_pc;
                end
                S_MEMRD: begin
                    mem_req  = 1'b1;
                    mem_addr = r_alu;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = r_alu;
                    mem_wdata = r_b;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_target  <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    r_a      <= r_rf[w_rs];
                    r_b      <= r_rf[w_rt];
                    r_target <= r_pc + (w_simm << 2);
                    if (w_next == S_HALT) r_illegal <= 1'b1;
                end
                S_MEMADR, S_ADDIEX: r_alu <= r_a + w_simm;
                S_MEMRD:  if (mem_ready) r_mdr <= mem_rdata;
                S_MEMWB:  if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
                S_EXEC:   r_alu <= w_alu;
                S_ALUWB:  if (w_rd != 5'd0) r_rf[w_rd] <= r_alu;
                S_ADDIWB: if (w_rt != 5'd0) r_rf[w_rt] <= r_alu;
                S_BRANCH: if (r_a == r_b) r_pc <= r_target;
                S_JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                S_HALT:   r_illegal <= 1'b1;
                default: ;
            endcase
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
